// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared FSM encoding, ALU opcode values and counter sizing
// for the two-port ALU arbiter. The optional opcode legality check is enabled
// with the ALU_ARB_OPRN_CHECK_EN macro and uses oprn_legal() below.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OPRN_ADD = 1;
    localparam int OPRN_SUB = 2;
    localparam int OPRN_MUL = 3;
    localparam int OPRN_SHR = 4;
    localparam int OPRN_SHL = 5;
    localparam int OPRN_AND = 6;
    localparam int OPRN_OR  = 7;
    localparam int OPRN_NOR = 8;
    localparam int OPRN_SLT = 9;

    localparam int OPRN_MIN = OPRN_ADD;
    localparam int OPRN_MAX = OPRN_SLT;

    // Busy counter holds up to 15 execute cycles for multiply.
    localparam int CNT_WIDTH = 4;

    // True when the opcode is one the ALU implements.
    function automatic logic oprn_legal(input logic [31:0] oprn);
        return (oprn >= 32'(OPRN_MIN)) && (oprn <= 32'(OPRN_MAX));
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// alu_arbiter_rr_arbiter2: two-way round-robin grant. A lone requester always
// wins; on a tie the requester that was not granted last time wins.
module alu_arbiter_rr_arbiter2 (
    input  logic valid_a,
    input  logic valid_b,
    input  logic last_grant,
    output logic grant_a,
    output logic grant_b
);

    // Grant selection; last_grant = 1 means B was served last, so A wins a tie.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (valid_a && valid_b) begin
            grant_a = last_grant;
            grant_b = !last_grant;
        end else begin
            grant_a = valid_a;
            grant_b = valid_b;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between requesters A
// (id 0) and B (id 1). Accepted operands are registered and drive the ALU;
// multiply is held for MUL_LATENCY execute cycles, every other opcode for one.
// The result is returned with the requester id under RSP_READY backpressure.
// Optional macro ALU_ARB_OPRN_CHECK_EN: opcodes outside 1..9 skip the ALU and
// return RSP_ERR = 1 one cycle after acceptance.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OPRN_WIDTH  = 6,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_VALID,
    output logic                  A_READY,
    input  logic [DATA_WIDTH-1:0] A_OP1,
    input  logic [DATA_WIDTH-1:0] A_OP2,
    input  logic [OPRN_WIDTH-1:0] A_OPRN,
    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic [DATA_WIDTH-1:0] B_OP1,
    input  logic [DATA_WIDTH-1:0] B_OP2,
    input  logic [OPRN_WIDTH-1:0] B_OPRN,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_OUT,
    output logic                  RSP_ZERO,
    output logic                  RSP_ID,
    output logic                  RSP_ERR
);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] op1_r;
    logic [DATA_WIDTH-1:0] op2_r;
    logic [OPRN_WIDTH-1:0] oprn_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  last_grant_r;
    logic [DATA_WIDTH-1:0] rsp_out_r;
    logic                  rsp_zero_r;
    logic                  rsp_id_r;
    logic                  grant_a;
    logic                  grant_b;
    logic                  ready_a;
    logic                  ready_b;
    logic                  xfer;
    logic                  load;
    logic                  finish;
    logic                  sel_id;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;
    logic [OPRN_WIDTH-1:0] sel_oprn;
`ifdef ALU_ARB_OPRN_CHECK_EN
    logic                  bypass;
    logic                  rsp_err_r;
`endif

    alu_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .valid_a    (A_VALID),
        .valid_b    (B_VALID),
        .last_grant (last_grant_r),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    // The granted requester's fields; only meaningful in an IDLE transfer cycle.
    assign sel_id   = grant_b;
    assign sel_op1  = grant_b ? B_OP1  : A_OP1;
    assign sel_op2  = grant_b ? B_OP2  : A_OP2;
    assign sel_oprn = grant_b ? B_OPRN : A_OPRN;

    assign A_READY   = ready_a;
    assign B_READY   = ready_b;
    assign ALU_OP1   = op1_r;
    assign ALU_OP2   = op2_r;
    assign ALU_OPRN  = oprn_r;
    assign RSP_VALID = (state == RESP);
    assign RSP_OUT   = rsp_out_r;
    assign RSP_ZERO  = rsp_zero_r;
    assign RSP_ID    = rsp_id_r;
`ifdef ALU_ARB_OPRN_CHECK_EN
    assign RSP_ERR   = rsp_err_r;
`else
    assign RSP_ERR   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the ready handshake and datapath strobes.
    always_comb begin
        state_nxt = state;
        ready_a   = 1'b0;
        ready_b   = 1'b0;
        xfer      = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
`ifdef ALU_ARB_OPRN_CHECK_EN
        bypass    = 1'b0;
`endif
        case (state)
            IDLE: begin
                ready_a = grant_a && !RST;
                ready_b = grant_b && !RST;
                if ((A_VALID && ready_a) || (B_VALID && ready_b)) begin
                    xfer = 1'b1;
`ifdef ALU_ARB_OPRN_CHECK_EN
                    if (!oprn_legal(32'(sel_oprn))) begin
                        bypass    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        load      = 1'b1;
                        state_nxt = EXEC;
                    end
`else
                    load      = 1'b1;
                    state_nxt = EXEC;
`endif
                end
            end
            EXEC: begin
                if (cnt_r == CNT_WIDTH'(1)) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, busy counter, round-robin history and result latch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op1_r        <= '0;
            op2_r        <= '0;
            oprn_r       <= '0;
            cnt_r        <= '0;
            last_grant_r <= 1'b1;
            rsp_out_r    <= '0;
            rsp_zero_r   <= 1'b0;
            rsp_id_r     <= 1'b0;
        end else begin
            if (xfer) begin
                last_grant_r <= sel_id;
                rsp_id_r     <= sel_id;
            end
            if (load) begin
                op1_r  <= sel_op1;
                op2_r  <= sel_op2;
                oprn_r <= sel_oprn;
                cnt_r  <= (sel_oprn == OPRN_WIDTH'(OPRN_MUL)) ?
                          CNT_WIDTH'(MUL_LATENCY) : CNT_WIDTH'(1);
            end else if (state == EXEC) begin
                cnt_r <= cnt_r - CNT_WIDTH'(1);
            end
            if (finish) begin
                rsp_out_r  <= ALU_OUT;
                rsp_zero_r <= ALU_ZERO;
            end
`ifdef ALU_ARB_OPRN_CHECK_EN
            if (bypass) begin
                rsp_out_r  <= '0;
                rsp_zero_r <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_ARB_OPRN_CHECK_EN
    // Error flag: set for a bypassed illegal opcode, cleared by any legal request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_err_r <= 1'b0;
        end else if (load) begin
            rsp_err_r <= 1'b0;
        end else if (bypass) begin
            rsp_err_r <= 1'b1;
        end
    end
`endif

endmodule
